// File: rtl/md_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: radix-2 shift-add multiply,
// restoring divide, WIDTH+1 cycles per long op with a final sign-fix/writeback cycle.
module md_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [2:0]       Md_op,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi_out,
  output logic [WIDTH-1:0] Lo_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MULT = 3'b000;
  localparam logic [2:0] OP_DIV  = 3'b010;
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MADD = 3'b110;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  // r_opa: multiplicand or divisor magnitude; r_part/r_quo: running high/low halves
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_part;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_a_lat;
  logic               r_neg_a;
  logic               r_neg_b;
  logic               r_is_div;
  logic               r_is_acc;
  logic               r_b_zero;

  logic               w_signed;
  logic               w_is_div;
  logic               w_is_acc;
  logic               w_is_move;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_sgn;
  logic [2*WIDTH-1:0] w_mul_res;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_signed  = (Md_op == OP_MULT) || (Md_op == OP_DIV) || (Md_op == OP_MADD);
  assign w_is_div  = (Md_op[2:1] == 2'b01);
  assign w_is_acc  = (Md_op[2:1] == 2'b11);
  assign w_is_move = (Md_op[2:1] == 2'b10);
  assign w_a_neg   = w_signed & A_in[WIDTH-1];
  assign w_b_neg   = w_signed & B_in[WIDTH-1];
  assign w_a_mag   = w_a_neg ? (-A_in) : A_in;
  assign w_b_mag   = w_b_neg ? (-B_in) : B_in;

  assign w_mul_sum   = {1'b0, r_part} + (r_quo[0] ? {1'b0, r_opa} : {(WIDTH+1){1'b0}});
  assign w_div_shift = {r_part, r_quo[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, r_opa};

  assign w_prod     = {r_part, r_quo};
  assign w_prod_sgn = (r_neg_a ^ r_neg_b) ? (-w_prod) : w_prod;
  assign w_mul_res  = r_is_acc ? (w_prod_sgn + {r_hi, r_lo}) : w_prod_sgn;
  assign w_quo_fix  = (r_neg_a ^ r_neg_b) ? (-r_quo) : r_quo;
  assign w_rem_fix  = r_neg_a ? (-r_part) : r_part;

  assign Busy   = r_busy;
  assign Done   = r_done;
  assign Hi_out = r_hi;
  assign Lo_out = r_lo;

  // Control FSM, iteration datapath and HI/LO writeback; reset > flush > start
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CNT_W{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= {WIDTH{1'b0}};
      r_lo     <= {WIDTH{1'b0}};
      r_opa    <= {WIDTH{1'b0}};
      r_part   <= {WIDTH{1'b0}};
      r_quo    <= {WIDTH{1'b0}};
      r_a_lat  <= {WIDTH{1'b0}};
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_is_div <= 1'b0;
      r_is_acc <= 1'b0;
      r_b_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (Flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (Start && w_is_move) begin
              if (Md_op == OP_MTHI) r_hi <= A_in;
              else                  r_lo <= A_in;
            end else if (Start) begin
              r_state  <= S_RUN;
              r_busy   <= 1'b1;
              r_cnt    <= {CNT_W{1'b0}};
              r_opa    <= w_is_div ? w_b_mag : w_a_mag;
              r_quo    <= w_is_div ? w_a_mag : w_b_mag;
              r_part   <= {WIDTH{1'b0}};
              r_a_lat  <= A_in;
              r_neg_a  <= w_a_neg;
              r_neg_b  <= w_b_neg;
              r_is_div <= w_is_div;
              r_is_acc <= w_is_acc;
              r_b_zero <= (B_in == {WIDTH{1'b0}});
            end
          end
          S_RUN: begin
            if (r_is_div) begin
              if (!w_div_diff[WIDTH]) begin
                r_part <= w_div_diff[WIDTH-1:0];
                r_quo  <= {r_quo[WIDTH-2:0], 1'b1};
              end else begin
                r_part <= w_div_shift[WIDTH-1:0];
                r_quo  <= {r_quo[WIDTH-2:0], 1'b0};
              end
            end else begin
              {r_part, r_quo} <= {w_mul_sum, r_quo[WIDTH-1:1]};
            end
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= S_FIX;
          end
          S_FIX: begin
            if (r_is_div && r_b_zero) begin
              r_hi <= r_a_lat;
              r_lo <= {WIDTH{1'b1}};
            end else if (r_is_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              {r_hi, r_lo} <= w_mul_res;
            end
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised iterative multiply/divide unit that owns the HI/LO register pair for the pipeline CPU.
- Sits beside the combinational ALU in EX.
- Accepts mult/multu/div/divu/madd/maddu/mthi/mtlo and runs the long operations over WIDTH+1 cycles.
- Raises Busy so the hazard unit stalls any mfhi/mflo or following md op until the result is written.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; must be at least 4.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  synchronous active-low reset.
- Start  input  1  request to issue Md_op with A_in/B_in this cycle.
- Md_op  input  3  opcode: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd, 111 maddu.
- A_in  input  WIDTH  rs operand; dividend for div/divu.
- B_in  input  WIDTH  rt operand; divisor for div/divu.
- Flush  input  1  abort the in-flight op (branch/exception squash).
- Busy  output  1  long op in flight; registered.
- Done  output  1  one-cycle pulse when HI/LO have just been written by a long op; registered.
- Hi_out  output  WIDTH  architectural HI; registered.
- Lo_out  output  WIDTH  architectural LO; registered.

Behaviour:
- Reset (Rst_n=0 at a rising edge):
  - state=IDLE, Busy=0, Done=0, Hi_out=0, Lo_out=0, counter=0.
  - Reset mid-operation discards the op and has the same effect.
- States:
  - IDLE: Busy=0.
  - RUN: Busy=1, WIDTH iterations.
  - FIX: Busy=1, one cycle of sign correction, accumulate and writeback.
  - Done is a registered pulse produced on the FIX->IDLE edge. There is no separate DONE state.
- Issue rules:
  - Start is accepted only when Busy=0.
  - Start while Busy=1 is ignored; the hazard unit must not issue it.
- mthi/mtlo:
  - Write Hi_out/Lo_out = A_in on the accepting edge.
  - State stays IDLE, Busy stays 0, no Done pulse.
- Long ops (mult, multu, div, divu, madd, maddu):
  - Accepting edge E0: latch the operands and signedness; state=RUN, Busy=1, counter=0.
  - Edges E1..E_WIDTH: one radix-2 step per edge.
    - Multiply: shift-add of |A|*|B| into a 2*WIDTH product.
    - Divide: restoring shift-subtract of |A|/|B|.
  - Edge E_WIDTH+1 (FIX): apply the sign correction, write Hi_out/Lo_out, Busy=0, Done=1 for exactly one cycle.
  - Latency: Start to Done high is WIDTH+1 cycles (33 for WIDTH=32).
  - Back-to-back: a new Start may be accepted in the Done-high cycle.
  - Hi_out/Lo_out hold their old values throughout RUN and change only on the FIX edge.
- Signed rules:
  - mult, madd and div treat operands as two's complement.
  - Product sign = sign(A) xor sign(B).
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
  - Results: HI = remainder, LO = quotient.
- multu, maddu, divu: operands unsigned.
- madd/maddu: {HI,LO} = {HI,LO} + product, modulo 2^(2*WIDTH). Uses the HI/LO value as of the FIX edge.
- Overflow case: div with A = most-negative and B = -1 gives LO = most-negative (wraps) and HI = 0. No flag is raised.
- Divide by zero (div or divu with B=0):
  - Normal latency, no trap.
  - Result is HI = A_in (latched value) and LO = all ones.
- Flush:
  - When Busy=1, the next edge returns the unit to IDLE with Busy=0 and no Done; HI/LO are unchanged.
  - Flush together with Start in the same cycle: Flush wins, nothing is issued (mthi/mtlo included).
  - Flush in the FIX cycle: the write is suppressed.
- Reset has priority over Flush, and Flush has priority over Start.
- No combinational path from any input to any output.

Test Plan:
- Reset with Rst_n=0 for 2 cycles -> Busy=0, Done=0, Hi_out=0, Lo_out=0.
- mult with A=0xFFFFFFFE, B=3 -> Busy high for 33 cycles, Done pulses at Start+33, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div with A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Edge divides:
  - div with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
  - divu with A=5, B=0 -> HI=5, LO=0xFFFFFFFF.
  - Both take 33 cycles.
- Move then accumulate:
  - mthi A=0 -> Busy stays 0, no Done.
  - mtlo A=0xFFFFFFFF.
  - Then maddu A=1, B=1 -> HI=1, LO=0.
- Issue and flush conflicts:
  - Start mult 7*9, then pulse Flush at cycle 10 -> Busy=0 next cycle, no Done, HI/LO unchanged.
  - Start while Busy -> ignored.
  - Start+Flush together -> no issue.
